// File: rtl/dispatch_queue_pkg.sv
// Shared dispatch types: renamed instruction layout, lane class and the classifier.
package common;

    localparam int DISP_WIDTH = 2;
    localparam int DISP_DEPTH = 8;

    typedef struct packed {
        logic is_branch;
        logic is_jump;
        logic is_jumpr;
        logic mem_read;
        logic mem_write;
    } control_type;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  prd;
        logic [4:0]  lrd;
        control_type control;
    } ir_is_type;

    typedef enum logic [0:0] {
        CLS_INT = 1'b0,
        CLS_MEM = 1'b1
    } disp_class_t;

    typedef struct packed {
        disp_class_t cls;
        logic        bj;
    } disp_cls_t;

    // Memory ops go to the mem ISQ; control-flow ops are int ops that also need a GHR checkpoint.
    function automatic disp_cls_t disp_classify(input control_type ctrl);
        disp_cls_t res;
        res.cls = (ctrl.mem_read | ctrl.mem_write) ? CLS_MEM : CLS_INT;
        res.bj  = (res.cls == CLS_INT) & (ctrl.is_branch | ctrl.is_jump | ctrl.is_jumpr);
        return res;
    endfunction

endpackage

// File: rtl/dispatch_queue_select.sv
// Combinational in-order prefix selector: dispatches the longest head prefix that fits all credits.
module dispatch_select
    import common::*;
#(
    parameter int WIDTH = DISP_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  control_type [WIDTH-1:0] head_control,
    input  logic [WIDTH-1:0]        head_valid,
    input  logic [CNT_W-1:0]        rob_left,
    input  logic [CNT_W-1:0]        intisq_left,
    input  logic [CNT_W-1:0]        memisq_left,
    input  logic [CNT_W-1:0]        GHT_left,
    output logic [WIDTH-1:0]        out_valid_rob,
    output logic [WIDTH-1:0]        out_valid_intisq,
    output logic [WIDTH-1:0]        out_valid_memisq,
    output logic [WIDTH-1:0]        ghsr_req,
    output logic [CNT_W-1:0]        dispatch_count
);

    logic             chain_ok_s;
    logic [CNT_W-1:0] rob_cnt_s, int_cnt_s, mem_cnt_s, bj_cnt_s;
    logic [CNT_W-1:0] rob_nxt_s, int_nxt_s, mem_nxt_s, bj_nxt_s;
    disp_cls_t        cls_s;

    // Walk lanes oldest-first; the first lane that misses a credit stops everything behind it.
    always_comb begin
        chain_ok_s       = 1'b1;
        rob_cnt_s        = '0;
        int_cnt_s        = '0;
        mem_cnt_s        = '0;
        bj_cnt_s         = '0;
        rob_nxt_s        = '0;
        int_nxt_s        = '0;
        mem_nxt_s        = '0;
        bj_nxt_s         = '0;
        cls_s            = '0;
        out_valid_rob    = '0;
        out_valid_intisq = '0;
        out_valid_memisq = '0;
        ghsr_req         = '0;
        dispatch_count   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            cls_s     = disp_classify(head_control[k]);
            rob_nxt_s = rob_cnt_s + CNT_W'(1);
            int_nxt_s = int_cnt_s + CNT_W'(cls_s.cls == CLS_INT);
            mem_nxt_s = mem_cnt_s + CNT_W'(cls_s.cls == CLS_MEM);
            bj_nxt_s  = bj_cnt_s + CNT_W'(cls_s.bj);
            if (chain_ok_s && head_valid[k] && (rob_nxt_s <= rob_left) &&
                (int_nxt_s <= intisq_left) && (mem_nxt_s <= memisq_left) &&
                (bj_nxt_s <= GHT_left)) begin
                out_valid_rob[k]    = 1'b1;
                out_valid_intisq[k] = (cls_s.cls == CLS_INT);
                out_valid_memisq[k] = (cls_s.cls == CLS_MEM);
                ghsr_req[k]         = cls_s.bj;
                rob_cnt_s           = rob_nxt_s;
                int_cnt_s           = int_nxt_s;
                mem_cnt_s           = mem_nxt_s;
                bj_cnt_s            = bj_nxt_s;
                dispatch_count      = rob_nxt_s;
            end else begin
                chain_ok_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// Buffered W-wide dispatch stage: compacting enqueue into a circular buffer, credit-limited in-order drain.
module dispatch_queue
    import common::*;
#(
    parameter int WIDTH = DISP_WIDTH,
    parameter int DEPTH = DISP_DEPTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush_valid,
    input  logic [WIDTH-1:0]            in_valid,
    input  ir_is_type [WIDTH-1:0]       in_entry,
    output logic                        in_ready,
    input  logic [CNT_W-1:0]            rob_left,
    input  logic [CNT_W-1:0]            intisq_left,
    input  logic [CNT_W-1:0]            memisq_left,
    input  logic [CNT_W-1:0]            GHT_left,
    output ir_is_type [WIDTH-1:0]       out_entry,
    output logic [WIDTH-1:0]            out_valid_rob,
    output logic [WIDTH-1:0]            out_valid_intisq,
    output logic [WIDTH-1:0]            out_valid_memisq,
    output logic [WIDTH-1:0]            ghsr_req,
    output logic [CNT_W-1:0]            dispatch_count,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    ir_is_type                  mem_r [DEPTH];
    logic [PTR_W-1:0]           head_r, tail_r;
    logic [OCC_W-1:0]           occupancy_r;

    ir_is_type [WIDTH-1:0]      head_entry_s;
    control_type [WIDTH-1:0]    head_control_s;
    logic [WIDTH-1:0]           head_valid_s;
    logic [PTR_W-1:0]           slot_s [WIDTH];
    logic [CNT_W-1:0]           enq_cnt_s;
    logic                       in_ready_s;
    logic                       push_s;

    // Readiness looks only at registered occupancy so credits never reach in_ready.
    assign in_ready_s = (occupancy_r <= OCC_W'(DEPTH - WIDTH)) && !flush_valid;
    assign push_s     = in_ready_s && (|in_valid);
    assign in_ready   = in_ready_s;
    assign occupancy  = occupancy_r;
    assign out_entry  = head_entry_s;

    // Present the head window; flush masks every lane so nothing leaves that cycle.
    always_comb begin
        head_entry_s   = '0;
        head_control_s = '0;
        head_valid_s   = '0;
        for (int k = 0; k < WIDTH; k++) begin
            head_entry_s[k]   = mem_r[head_r + PTR_W'(k)];
            head_control_s[k] = head_entry_s[k].control;
            head_valid_s[k]   = (OCC_W'(k) < occupancy_r) && !flush_valid;
        end
    end

    // Compact valid lanes into consecutive tail slots.
    always_comb begin
        enq_cnt_s = '0;
        for (int k = 0; k < WIDTH; k++) begin
            slot_s[k] = tail_r + PTR_W'(enq_cnt_s);
            if (in_valid[k]) begin
                enq_cnt_s = enq_cnt_s + CNT_W'(1);
            end else begin
                enq_cnt_s = enq_cnt_s;
            end
        end
    end

    dispatch_select #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_select (
        .head_control     (head_control_s),
        .head_valid       (head_valid_s),
        .rob_left         (rob_left),
        .intisq_left      (intisq_left),
        .memisq_left      (memisq_left),
        .GHT_left         (GHT_left),
        .out_valid_rob    (out_valid_rob),
        .out_valid_intisq (out_valid_intisq),
        .out_valid_memisq (out_valid_memisq),
        .ghsr_req         (ghsr_req),
        .dispatch_count   (dispatch_count)
    );

    // Entry storage; contents beyond occupancy are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (push_s && in_valid[k]) begin
                mem_r[slot_s[k]] <= in_entry[k];
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset and flush both empty the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r      <= '0;
            tail_r      <= '0;
            occupancy_r <= '0;
        end else if (flush_valid) begin
            head_r      <= '0;
            tail_r      <= '0;
            occupancy_r <= '0;
        end else begin
            head_r <= head_r + PTR_W'(dispatch_count);
            if (push_s) begin
                tail_r      <= tail_r + PTR_W'(enq_cnt_s);
                occupancy_r <= occupancy_r + OCC_W'(enq_cnt_s) - OCC_W'(dispatch_count);
            end else begin
                tail_r      <= tail_r;
                occupancy_r <= occupancy_r - OCC_W'(dispatch_count);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue (WIDTH=2, DEPTH=8) with hand-computed expectations.
module tb_dispatch_queue;
    import common::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush_valid;
    logic [1:0]      in_valid;
    ir_is_type [1:0] in_entry;
    logic            in_ready;
    logic [1:0]      rob_left, intisq_left, memisq_left, GHT_left;
    ir_is_type [1:0] out_entry;
    logic [1:0]      out_valid_rob, out_valid_intisq, out_valid_memisq, ghsr_req;
    logic [1:0]      dispatch_count;
    logic [3:0]      occupancy;

    int tests  = 0;
    int failed = 0;

    dispatch_queue #(.WIDTH(2), .DEPTH(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush_valid      (flush_valid),
        .in_valid         (in_valid),
        .in_entry         (in_entry),
        .in_ready         (in_ready),
        .rob_left         (rob_left),
        .intisq_left      (intisq_left),
        .memisq_left      (memisq_left),
        .GHT_left         (GHT_left),
        .out_entry        (out_entry),
        .out_valid_rob    (out_valid_rob),
        .out_valid_intisq (out_valid_intisq),
        .out_valid_memisq (out_valid_memisq),
        .ghsr_req         (ghsr_req),
        .dispatch_count   (dispatch_count),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, checks 2 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic credits(input logic [1:0] r, input logic [1:0] i, input logic [1:0] m, input logic [1:0] g);
        rob_left = r; intisq_left = i; memisq_left = m; GHT_left = g;
    endtask

    function automatic ir_is_type mk(input logic [31:0] pc, input logic ld, input logic br, input logic jl);
        ir_is_type e;
        e = '0;
        e.pc                = pc;
        e.control.mem_read  = ld;
        e.control.is_branch = br;
        e.control.is_jump   = jl;
        return e;
    endfunction

    initial begin
        reset = 1'b1; flush_valid = 1'b0; in_valid = 2'b00; in_entry = '0;
        credits(2'd0, 2'd0, 2'd0, 2'd0);
        tick(); tick();
        reset = 1'b0;
        tick(); settle();
        chk("reset_occ", 64'(occupancy), 64'd0);
        chk("reset_rob", 64'(out_valid_rob), 64'd0);
        chk("reset_cnt", 64'(dispatch_count), 64'd0);
        chk("reset_rdy", 64'(in_ready), 64'd1);

        // Two ALU ops, full credits
        tick();
        credits(2'd2, 2'd2, 2'd2, 2'd2);
        in_valid = 2'b11; in_entry[0] = mk(32'h10, 1'b0, 1'b0, 1'b0); in_entry[1] = mk(32'h14, 1'b0, 1'b0, 1'b0);
        settle();
        chk("empty_cnt", 64'(dispatch_count), 64'd0);
        tick();
        in_valid = 2'b00; settle();
        chk("alu_occ", 64'(occupancy), 64'd2);
        chk("alu_rob", 64'(out_valid_rob), 64'h3);
        chk("alu_int", 64'(out_valid_intisq), 64'h3);
        chk("alu_mem", 64'(out_valid_memisq), 64'h0);
        chk("alu_cnt", 64'(dispatch_count), 64'd2);
        chk("alu_pc0", 64'(out_entry[0].pc), 64'h10);
        tick(); settle();
        chk("alu_drain", 64'(occupancy), 64'd0);

        // {load, add} with no mem credit: nothing leaves
        credits(2'd2, 2'd2, 2'd0, 2'd2);
        in_valid = 2'b11; in_entry[0] = mk(32'h20, 1'b1, 1'b0, 1'b0); in_entry[1] = mk(32'h24, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 2'b00; settle();
        chk("ld_blk_cnt", 64'(dispatch_count), 64'd0);
        chk("ld_blk_rob", 64'(out_valid_rob), 64'h0);
        tick(); settle();
        chk("ld_blk_occ", 64'(occupancy), 64'd2);
        credits(2'd2, 2'd2, 2'd2, 2'd2); settle();
        chk("ld_go_mem", 64'(out_valid_memisq), 64'h1);
        chk("ld_go_int", 64'(out_valid_intisq), 64'h2);
        tick(); settle();
        chk("ld_go_occ", 64'(occupancy), 64'd0);

        // {add, load} with no mem credit: add alone
        credits(2'd2, 2'd2, 2'd0, 2'd2);
        in_valid = 2'b11; in_entry[0] = mk(32'h30, 1'b0, 1'b0, 1'b0); in_entry[1] = mk(32'h34, 1'b1, 1'b0, 1'b0);
        tick();
        in_valid = 2'b00; settle();
        chk("add_ld_rob", 64'(out_valid_rob), 64'h1);
        chk("add_ld_cnt", 64'(dispatch_count), 64'd1);
        tick(); settle();
        chk("add_ld_occ", 64'(occupancy), 64'd1);
        chk("add_ld_head", 64'(out_entry[0].pc), 64'h34);
        chk("add_ld_stall", 64'(out_valid_rob), 64'h0);
        credits(2'd2, 2'd2, 2'd1, 2'd2); settle();
        chk("ld_mem1", 64'(out_valid_memisq), 64'h1);
        tick(); settle();
        chk("ld_mem1_occ", 64'(occupancy), 64'd0);

        // {beq, jal} with one GHR credit
        credits(2'd2, 2'd2, 2'd2, 2'd1);
        in_valid = 2'b11; in_entry[0] = mk(32'h40, 1'b0, 1'b1, 1'b0); in_entry[1] = mk(32'h44, 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 2'b00; settle();
        chk("bj_ghsr", 64'(ghsr_req), 64'h1);
        chk("bj_cnt", 64'(dispatch_count), 64'd1);
        chk("bj_int", 64'(out_valid_intisq), 64'h1);
        tick();
        credits(2'd2, 2'd2, 2'd2, 2'd2); settle();
        chk("jal_ghsr", 64'(ghsr_req), 64'h1);
        chk("jal_cnt", 64'(dispatch_count), 64'd1);
        chk("jal_pc", 64'(out_entry[0].pc), 64'h44);
        tick(); settle();
        chk("jal_occ", 64'(occupancy), 64'd0);

        // Fill to 7 with no credits (head=tail=0 here)
        credits(2'd0, 2'd0, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 2'b11;
            in_entry[0] = mk(32'h100 + 32'(8 * i), 1'b0, 1'b0, 1'b0);
            in_entry[1] = mk(32'h104 + 32'(8 * i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        in_valid = 2'b01; in_entry[0] = mk(32'h118, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 2'b00; settle();
        chk("full_occ", 64'(occupancy), 64'd7);
        chk("full_rdy", 64'(in_ready), 64'd0);
        credits(2'd2, 2'd2, 2'd2, 2'd2); settle();
        chk("drain0_pc0", 64'(out_entry[0].pc), 64'h100);
        chk("drain0_pc1", 64'(out_entry[1].pc), 64'h104);
        tick();
        in_valid = 2'b11; in_entry[0] = mk(32'h11c, 1'b0, 1'b0, 1'b0); in_entry[1] = mk(32'h120, 1'b0, 1'b0, 1'b0);
        settle();
        chk("drain1_rdy", 64'(in_ready), 64'd1);
        chk("drain1_pc0", 64'(out_entry[0].pc), 64'h108);
        chk("drain1_pc1", 64'(out_entry[1].pc), 64'h10c);
        tick();
        in_valid = 2'b00; settle();
        chk("drain2_occ", 64'(occupancy), 64'd5);
        chk("drain2_pc0", 64'(out_entry[0].pc), 64'h110);
        chk("drain2_pc1", 64'(out_entry[1].pc), 64'h114);
        tick(); settle();
        chk("wrap_pc0", 64'(out_entry[0].pc), 64'h118);
        chk("wrap_pc1", 64'(out_entry[1].pc), 64'h11c);
        tick(); settle();
        chk("last_occ", 64'(occupancy), 64'd1);
        chk("last_rob", 64'(out_valid_rob), 64'h1);
        chk("last_pc", 64'(out_entry[0].pc), 64'h120);
        tick(); settle();
        chk("wrap_empty", 64'(occupancy), 64'd0);

        // Build occupancy 5, then flush with a full input group
        credits(2'd0, 2'd0, 2'd0, 2'd0);
        in_valid = 2'b11; in_entry[0] = mk(32'h200, 1'b0, 1'b0, 1'b0); in_entry[1] = mk(32'h204, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        in_valid = 2'b01;
        tick();
        in_valid = 2'b00; settle();
        chk("pre_flush_occ", 64'(occupancy), 64'd5);
        flush_valid = 1'b1; in_valid = 2'b11;
        credits(2'd2, 2'd2, 2'd2, 2'd2); settle();
        chk("flush_rdy", 64'(in_ready), 64'd0);
        chk("flush_rob", 64'(out_valid_rob), 64'h0);
        chk("flush_cnt", 64'(dispatch_count), 64'd0);
        tick();
        flush_valid = 1'b0; in_valid = 2'b00; settle();
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_nodisp", 64'(out_valid_rob), 64'h0);
        in_valid = 2'b01; in_entry[0] = mk(32'h300, 1'b0, 1'b0, 1'b0);
        tick();
        in_valid = 2'b00; settle();
        chk("post_flush_pc", 64'(out_entry[0].pc), 64'h300);
        chk("post_flush_cnt", 64'(dispatch_count), 64'd1);
        tick();

        // Mid-operation reset discards entries
        credits(2'd0, 2'd0, 2'd0, 2'd0);
        in_valid = 2'b11;
        tick();
        in_valid = 2'b00; reset = 1'b1;
        tick();
        reset = 1'b0; settle();
        chk("midrst_occ", 64'(occupancy), 64'd0);
        chk("midrst_rdy", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
